stage_writeback: RTL and testbench

Final pipeline stage of the processor, directly downstream of the memory stage. Registers the memory stage's ALU result, load data and destination control in a MEM/WB pipeline register. Selects the write-back value and drives the register-file write port and the WB→EX forwarding bus. Maintains a retired-instruction counter.

---
 rtl/stage_writeback_pkg.sv | 21 ++
 rtl/stage_writeback_if.sv | 50 +++++
 rtl/stage_writeback_retire_counter.sv | 44 ++++
 rtl/stage_writeback.sv | 116 +++++++++++
 tb/tb_stage_writeback.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_writeback_pkg.sv
// -----------------------------------------------------------------------------
// stage_writeback_pkg
//   Shared definitions for the write-back stage.
//   - Default datapath and register-index widths.
//   - Bit positions of the MEM->WB control bundle (valid, wr, mem_to_reg).
// -----------------------------------------------------------------------------
package stage_writeback_pkg;

   localparam int DEF_DBITS               = 32;
   localparam int DEF_REG_INDEX_BIT_WIDTH = 4;
   localparam int DEF_RETIRE_CNT_BITS     = 32;

   // Control bundle carried from the memory stage into the MEM/WB register.
   localparam int CTL_WR_BIT         = 0;
   localparam int CTL_MEM_TO_REG_BIT = 1;
   localparam int CTL_VALID_BIT      = 2;
   localparam int CTL_BITS           = 3;

   typedef logic [CTL_BITS-1:0] mem_wb_ctl_t;

endpackage

// File: rtl/stage_writeback_if.sv
// -----------------------------------------------------------------------------
// stage_writeback_if
//   Bundle between the memory stage / control (master) and the write-back
//   stage (slave).
//   master -> slave : in_valid, in_alu_out, in_mem_data, in_dst_reg,
//                     in_wr_reg, in_mem_to_reg, flush, hold, cnt_clear
//   slave -> master : wb_en, wb_idx, wb_data (register-file write port),
//                     fwd_valid, fwd_idx, fwd_data (WB->EX forwarding),
//                     retire_pulse, retire_count
// -----------------------------------------------------------------------------
interface stage_writeback_if #(
   parameter int DBITS               = stage_writeback_pkg::DEF_DBITS,
   parameter int REG_INDEX_BIT_WIDTH = stage_writeback_pkg::DEF_REG_INDEX_BIT_WIDTH,
   parameter int RETIRE_CNT_BITS     = stage_writeback_pkg::DEF_RETIRE_CNT_BITS
);

   logic                           in_valid;
   logic [DBITS-1:0]               in_alu_out;
   logic [DBITS-1:0]               in_mem_data;
   logic [REG_INDEX_BIT_WIDTH-1:0] in_dst_reg;
   logic                           in_wr_reg;
   logic                           in_mem_to_reg;
   logic                           flush;
   logic                           hold;
   logic                           cnt_clear;

   logic                           wb_en;
   logic [REG_INDEX_BIT_WIDTH-1:0] wb_idx;
   logic [DBITS-1:0]               wb_data;
   logic                           fwd_valid;
   logic [REG_INDEX_BIT_WIDTH-1:0] fwd_idx;
   logic [DBITS-1:0]               fwd_data;
   logic                           retire_pulse;
   logic [RETIRE_CNT_BITS-1:0]     retire_count;

   modport master (
      output in_valid, in_alu_out, in_mem_data, in_dst_reg, in_wr_reg,
             in_mem_to_reg, flush, hold, cnt_clear,
      input  wb_en, wb_idx, wb_data, fwd_valid, fwd_idx, fwd_data,
             retire_pulse, retire_count
   );

   modport slave (
      input  in_valid, in_alu_out, in_mem_data, in_dst_reg, in_wr_reg,
             in_mem_to_reg, flush, hold, cnt_clear,
      output wb_en, wb_idx, wb_data, fwd_valid, fwd_idx, fwd_data,
             retire_pulse, retire_count
   );

endinterface

// File: rtl/stage_writeback_retire_counter.sv
// -----------------------------------------------------------------------------
// retire_counter
//   Free-running retired-instruction counter.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset (count -> 0)
//   clear : synchronous clear, wins over inc
//   inc   : add one this edge (wraps from all-ones to 0)
//   count : current count
// -----------------------------------------------------------------------------
module retire_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/stage_writeback.sv
// -----------------------------------------------------------------------------
// stage_writeback
//   Final pipeline stage. Captures the memory stage's result into the MEM/WB
//   register, drives the register-file write port and the WB->EX forwarding
//   bus from that register, and counts retired instructions.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : stage_writeback_if.slave (inputs from memory stage, hold/flush/
//           cnt_clear controls, write-back / forwarding / retire outputs)
//   Outputs depend only on the stage register and hold, never on in_*.
// -----------------------------------------------------------------------------
module stage_writeback #(
   parameter int DBITS               = stage_writeback_pkg::DEF_DBITS,
   parameter int REG_INDEX_BIT_WIDTH = stage_writeback_pkg::DEF_REG_INDEX_BIT_WIDTH,
   parameter int RETIRE_CNT_BITS     = stage_writeback_pkg::DEF_RETIRE_CNT_BITS,
   parameter int ZERO_REG_HARDWIRED  = 0
) (
   input  logic             clk,
   input  logic             reset,
   stage_writeback_if.slave bus
);

   import stage_writeback_pkg::*;

   mem_wb_ctl_t in_ctl;

   logic                           valid_q,     valid_d;
   logic                           committed_q, committed_d;
   logic                           wr_q,        wr_d;
   logic [REG_INDEX_BIT_WIDTH-1:0] dst_q,       dst_d;
   logic [DBITS-1:0]               data_q,      data_d;

   logic commit;
   logic r0_target;

   // Pack the incoming control bits into the MEM->WB bundle layout.
   always_comb begin
      in_ctl                     = '0;
      in_ctl[CTL_VALID_BIT]      = bus.in_valid;
      in_ctl[CTL_WR_BIT]         = bus.in_wr_reg;
      in_ctl[CTL_MEM_TO_REG_BIT] = bus.in_mem_to_reg;
   end

   // An entry commits in the first cycle it is live and not frozen. The
   // committed bit stops a held entry from firing a second time; any edge
   // that is not held re-captures the register and clears it again.
   assign commit = valid_q & ~committed_q & ~bus.hold;

   always_comb begin
      valid_d     = valid_q;
      committed_d = committed_q | commit;
      wr_d        = wr_q;
      dst_d       = dst_q;
      data_d      = data_q;
      if (bus.hold) begin
         // Freeze everything, even if flush is also asserted.
         committed_d = committed_q;
      end else if (bus.flush) begin
         valid_d     = 1'b0;
         committed_d = 1'b0;
      end else begin
         valid_d     = in_ctl[CTL_VALID_BIT];
         committed_d = 1'b0;
         wr_d        = in_ctl[CTL_WR_BIT];
         dst_d       = bus.in_dst_reg;
         // Write-back value is selected at capture so the output path is a
         // plain register read.
         data_d      = in_ctl[CTL_MEM_TO_REG_BIT] ? bus.in_mem_data : bus.in_alu_out;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q     <= 1'b0;
         committed_q <= 1'b0;
         wr_q        <= 1'b0;
         dst_q       <= '0;
         data_q      <= '0;
      end else begin
         valid_q     <= valid_d;
         committed_q <= committed_d;
         wr_q        <= wr_d;
         dst_q       <= dst_d;
         data_q      <= data_d;
      end
   end

   // Register 0 as a hardwired zero: the write is dropped, the instruction
   // still retires.
   generate
      if (ZERO_REG_HARDWIRED != 0) begin : g_r0_hardwired
         assign r0_target = (dst_q == '0);
      end else begin : g_r0_writable
         assign r0_target = 1'b0;
      end
   endgenerate

   assign bus.wb_en        = commit & wr_q & ~r0_target;
   assign bus.wb_idx       = dst_q;
   assign bus.wb_data      = data_q;
   assign bus.fwd_valid    = bus.wb_en;
   assign bus.fwd_idx      = dst_q;
   assign bus.fwd_data     = data_q;
   assign bus.retire_pulse = commit;

   retire_counter #(
      .WIDTH (RETIRE_CNT_BITS)
   ) u_retire_counter (
      .clk   (clk),
      .reset (reset),
      .clear (bus.cnt_clear),
      .inc   (commit),
      .count (bus.retire_count)
   );

endmodule

// File: tb/tb_stage_writeback.sv
// -----------------------------------------------------------------------------
// tb_stage_writeback
//   Two instances share one stimulus stream:
//     dut_a : ZERO_REG_HARDWIRED=0, 32-bit retire counter
//     dut_b : ZERO_REG_HARDWIRED=1, 4-bit retire counter (reaches wrap quickly)
//   Expected write-back transactions are queued when stimulus is issued and
//   popped by a monitor whenever a DUT raises retire_pulse.
// -----------------------------------------------------------------------------
module tb_stage_writeback;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_alu_out = '0;
   logic [31:0] in_mem_data = '0;
   logic [3:0]  in_dst_reg = '0;
   logic        in_wr_reg = 1'b0;
   logic        in_mem_to_reg = 1'b0;
   logic        flush = 1'b0;
   logic        hold = 1'b0;
   logic        cnt_clear = 1'b0;

   always #5 clk = ~clk;

   stage_writeback_if #(.DBITS(32), .REG_INDEX_BIT_WIDTH(4), .RETIRE_CNT_BITS(32)) bus_a ();
   stage_writeback_if #(.DBITS(32), .REG_INDEX_BIT_WIDTH(4), .RETIRE_CNT_BITS(4))  bus_b ();

   assign bus_a.in_valid      = in_valid;
   assign bus_a.in_alu_out    = in_alu_out;
   assign bus_a.in_mem_data   = in_mem_data;
   assign bus_a.in_dst_reg    = in_dst_reg;
   assign bus_a.in_wr_reg     = in_wr_reg;
   assign bus_a.in_mem_to_reg = in_mem_to_reg;
   assign bus_a.flush         = flush;
   assign bus_a.hold          = hold;
   assign bus_a.cnt_clear     = cnt_clear;

   assign bus_b.in_valid      = in_valid;
   assign bus_b.in_alu_out    = in_alu_out;
   assign bus_b.in_mem_data   = in_mem_data;
   assign bus_b.in_dst_reg    = in_dst_reg;
   assign bus_b.in_wr_reg     = in_wr_reg;
   assign bus_b.in_mem_to_reg = in_mem_to_reg;
   assign bus_b.flush         = flush;
   assign bus_b.hold          = hold;
   assign bus_b.cnt_clear     = cnt_clear;

   stage_writeback #(
      .DBITS(32), .REG_INDEX_BIT_WIDTH(4), .RETIRE_CNT_BITS(32), .ZERO_REG_HARDWIRED(0)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   stage_writeback #(
      .DBITS(32), .REG_INDEX_BIT_WIDTH(4), .RETIRE_CNT_BITS(4), .ZERO_REG_HARDWIRED(1)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   typedef struct packed {
      logic        en;
      logic [3:0]  idx;
      logic [31:0] data;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea;
   exp_t eb;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   // Queue the expected write-back for both instances.
   task automatic push_exp(input logic en_a, input logic en_b, input logic [3:0] idx,
                           input logic [31:0] data);
      q_a.push_back('{en: en_a, idx: idx, data: data});
      q_b.push_back('{en: en_b, idx: idx, data: data});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                          input logic [3:0] dst, input logic wr, input logic m2r);
      in_valid      = v;
      in_alu_out    = alu;
      in_mem_data   = mem;
      in_dst_reg    = dst;
      in_wr_reg     = wr;
      in_mem_to_reg = m2r;
   endtask

   task automatic idle();
      in_valid      = 1'b0;
      in_wr_reg     = 1'b0;
      in_mem_to_reg = 1'b0;
      flush         = 1'b0;
      hold          = 1'b0;
      cnt_clear     = 1'b0;
   endtask

   // Monitor: one transaction per retire pulse per instance.
   always @(negedge clk) begin
      if (bus_a.retire_pulse === 1'b1) begin
         if (q_a.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL a_unexpected_retire: got retire_pulse=1, required 0 (no pending entry)");
         end else begin
            ea = q_a.pop_front();
            $display("txn a: wb_en=%0b idx=%0d data=0x%08h (req en=%0b idx=%0d data=0x%08h)",
                     bus_a.wb_en, bus_a.wb_idx, bus_a.wb_data, ea.en, ea.idx, ea.data);
            check("a_wb_en",     32'(bus_a.wb_en),     32'(ea.en));
            check("a_wb_idx",    32'(bus_a.wb_idx),    32'(ea.idx));
            check("a_wb_data",   bus_a.wb_data,        ea.data);
            check("a_fwd_valid", 32'(bus_a.fwd_valid), 32'(ea.en));
            check("a_fwd_idx",   32'(bus_a.fwd_idx),   32'(ea.idx));
            check("a_fwd_data",  bus_a.fwd_data,       ea.data);
         end
      end
      if (bus_b.retire_pulse === 1'b1) begin
         if (q_b.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b_unexpected_retire: got retire_pulse=1, required 0 (no pending entry)");
         end else begin
            eb = q_b.pop_front();
            $display("txn b: wb_en=%0b idx=%0d data=0x%08h (req en=%0b idx=%0d data=0x%08h)",
                     bus_b.wb_en, bus_b.wb_idx, bus_b.wb_data, eb.en, eb.idx, eb.data);
            check("b_wb_en",     32'(bus_b.wb_en),     32'(eb.en));
            check("b_wb_idx",    32'(bus_b.wb_idx),    32'(eb.idx));
            check("b_wb_data",   bus_b.wb_data,        eb.data);
            check("b_fwd_valid", 32'(bus_b.fwd_valid), 32'(eb.en));
         end
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held low across two edges.
      tick();
      tick();
      check("rst_wb_en",        32'(bus_a.wb_en),        32'h0);
      check("rst_wb_idx",       32'(bus_a.wb_idx),       32'h0);
      check("rst_wb_data",      bus_a.wb_data,           32'h0);
      check("rst_fwd_valid",    32'(bus_a.fwd_valid),    32'h0);
      check("rst_retire_pulse", 32'(bus_a.retire_pulse), 32'h0);
      check("rst_retire_count", bus_a.retire_count,      32'h0);
      reset = 1'b1;

      // Single ALU write.
      present(1'b1, 32'h0000_1234, 32'h0, 4'd5, 1'b1, 1'b0);
      push_exp(1'b1, 1'b1, 4'd5, 32'h0000_1234);
      tick();
      check("alu_count_before", bus_a.retire_count, 32'd0);
      idle();
      tick();
      check("alu_count_after", bus_a.retire_count, 32'd1);

      // Load select.
      present(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'd3, 1'b1, 1'b1);
      push_exp(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF);
      tick();
      idle();
      tick();

      // Non-writing instruction still retires.
      present(1'b1, 32'h0000_0055, 32'h0, 4'd6, 1'b0, 1'b0);
      push_exp(1'b0, 1'b0, 4'd6, 32'h0000_0055);
      tick();
      idle();
      tick();
      check("nowr_count", bus_a.retire_count, 32'd3);

      // Flush kills the incoming instruction.
      present(1'b1, 32'h0000_0066, 32'h0, 4'd8, 1'b1, 1'b0);
      flush = 1'b1;
      tick();
      check("flush_wb_en",        32'(bus_a.wb_en),        32'h0);
      check("flush_retire_pulse", 32'(bus_a.retire_pulse), 32'h0);
      idle();
      tick();
      check("flush_count", bus_a.retire_count, 32'd3);

      // Hold after commit: entry retires once, held bubble stays unchanged.
      present(1'b1, 32'h0000_0077, 32'h0, 4'd7, 1'b1, 1'b0);
      push_exp(1'b1, 1'b1, 4'd7, 32'h0000_0077);
      tick();
      present(1'b0, 32'h0000_0099, 32'h0, 4'd9, 1'b1, 1'b0);
      tick();
      hold = 1'b1;
      present(1'b1, 32'h0000_0BAD, 32'h0, 4'd12, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_idx",   32'(bus_a.wb_idx), 32'd9);
         check("hold_data",  bus_a.wb_data,     32'h0000_0099);
         check("hold_wb_en", 32'(bus_a.wb_en),  32'h0);
      end
      idle();
      tick();
      tick();
      check("hold_after_count", bus_a.retire_count, 32'd4);

      // Hold plus flush before commit: entry survives and commits once.
      present(1'b1, 32'h0000_00AA, 32'h0, 4'd10, 1'b1, 1'b0);
      push_exp(1'b1, 1'b1, 4'd10, 32'h0000_00AA);
      tick();
      hold  = 1'b1;
      flush = 1'b1;
      present(1'b1, 32'h0000_0BAD, 32'h0, 4'd13, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hflush_idx",  32'(bus_a.wb_idx), 32'd10);
         check("hflush_data", bus_a.wb_data,     32'h0000_00AA);
      end
      idle();
      tick();
      check("hflush_count", bus_a.retire_count, 32'd5);
      tick();
      check("hflush_count_once", bus_a.retire_count, 32'd5);

      // r0 write: suppressed only on the hardwired instance, retires on both.
      present(1'b1, 32'h0000_0123, 32'h0, 4'd0, 1'b1, 1'b0);
      push_exp(1'b1, 1'b0, 4'd0, 32'h0000_0123);
      tick();
      idle();
      tick();
      check("r0_count_b", 32'(bus_b.retire_count), 32'd6);

      // Back-to-back writes to bring the 4-bit counter to 15.
      for (int i = 0; i < 9; i++) begin
         present(1'b1, 32'h0000_1000 + 32'(i), 32'h0, 4'(i + 1), 1'b1, 1'b0);
         push_exp(1'b1, 1'b1, 4'(i + 1), 32'h0000_1000 + 32'(i));
         tick();
      end
      idle();
      tick();
      check("pre_wrap_count_a", bus_a.retire_count,        32'd15);
      check("pre_wrap_count_b", 32'(bus_b.retire_count),   32'd15);

      // One more commit: 4-bit counter wraps to 0.
      present(1'b1, 32'h0000_00F0, 32'h0, 4'd2, 1'b1, 1'b0);
      push_exp(1'b1, 1'b1, 4'd2, 32'h0000_00F0);
      tick();
      idle();
      tick();
      check("wrap_count_a", bus_a.retire_count,      32'd16);
      check("wrap_count_b", 32'(bus_b.retire_count), 32'd0);

      // Clear coincident with a commit.
      present(1'b1, 32'h0000_00C1, 32'h0, 4'd4, 1'b1, 1'b0);
      push_exp(1'b1, 1'b1, 4'd4, 32'h0000_00C1);
      tick();
      idle();
      cnt_clear = 1'b1;
      tick();
      cnt_clear = 1'b0;
      check("clear_count_a", bus_a.retire_count,      32'd0);
      check("clear_count_b", 32'(bus_b.retire_count), 32'd0);
      present(1'b1, 32'h0000_00C2, 32'h0, 4'd4, 1'b1, 1'b0);
      push_exp(1'b1, 1'b1, 4'd4, 32'h0000_00C2);
      tick();
      idle();
      tick();
      check("post_clear_count_a", bus_a.retire_count, 32'd1);

      // Reset pulsed mid-hold; the held entry never commits.
      present(1'b1, 32'h0000_00E5, 32'h0, 4'd11, 1'b1, 1'b0);
      tick();
      hold     = 1'b1;
      in_valid = 1'b0;
      tick();
      check("mid_hold_idx", 32'(bus_a.wb_idx), 32'd11);
      #2;
      reset = 1'b0;
      #1;
      check("rstmid_wb_en",        32'(bus_a.wb_en),        32'h0);
      check("rstmid_wb_idx",       32'(bus_a.wb_idx),       32'h0);
      check("rstmid_wb_data",      bus_a.wb_data,           32'h0);
      check("rstmid_fwd_data",     bus_a.fwd_data,          32'h0);
      check("rstmid_retire_pulse", 32'(bus_a.retire_pulse), 32'h0);
      check("rstmid_retire_count", bus_a.retire_count,      32'h0);
      tick();
      check("rstlow_wb_idx",       32'(bus_a.wb_idx),       32'h0);
      check("rstlow_retire_count", bus_a.retire_count,      32'h0);
      reset = 1'b1;
      idle();
      tick();
      tick();
      check("post_rst_count", bus_a.retire_count, 32'h0);

      // Every queued transaction must have been seen.
      check("pending_a", 32'(q_a.size()), 32'd0);
      check("pending_b", 32'(q_b.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
